// File: rtl/agdc_timed.sv
// agdc_timed: garage door controller with rising-edge activation,
// stop-mid-travel, obstruction auto-reverse and a motor-run watchdog
// that latches a fault. State and motor/fault outputs are registered
// together, so every output reflects the state entered at the last edge.
module agdc_timed #(
  parameter int TIMEOUT_W   = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Activate,
  input  logic       UP_Max,
  input  logic       DN_Max,
  input  logic       Obst,
  output logic       UP_M,
  output logic       DN_M,
  output logic       Fault,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MV_UP   = 3'd1,
    S_MV_DN   = 3'd2,
    S_STOPPED = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  // Count value seen on the last permitted motor-on cycle.
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);
  localparam logic [TIMEOUT_W-1:0] CNT_MAX  = '1;

  state_t                 state_q, state_d;
  logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
  logic                   last_dir_q, last_dir_d;
  logic                   act_q;
  logic                   up_m_q, dn_m_q, fault_q;

  logic act_p;
  logic limit_conflict;
  logic timeout_hit;
  logic moving_q;
  logic entering_move;

  assign act_p          = Activate & ~act_q;
  assign limit_conflict = UP_Max & DN_Max;
  assign timeout_hit    = (cnt_q == CNT_LAST);
  assign moving_q       = (state_q == S_MV_UP) || (state_q == S_MV_DN);

  // Next-state decision; a limit conflict overrides everything, and it also
  // keeps the door in FAULT while both limits remain asserted.
  always_comb begin
    state_d = state_q;
    if (limit_conflict) begin
      state_d = S_FAULT;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (act_p) state_d = UP_Max ? S_MV_DN : S_MV_UP;
        end
        S_MV_UP: begin
          if (UP_Max)           state_d = S_IDLE;
          else if (timeout_hit) state_d = S_FAULT;
          else if (act_p)       state_d = S_STOPPED;
        end
        S_MV_DN: begin
          if (DN_Max)           state_d = S_IDLE;
          else if (Obst)        state_d = S_MV_UP;
          else if (timeout_hit) state_d = S_FAULT;
          else if (act_p)       state_d = S_STOPPED;
        end
        S_STOPPED: begin
          if (act_p) begin
            if (!last_dir_q) state_d = UP_Max ? S_IDLE : S_MV_UP;
            else             state_d = DN_Max ? S_IDLE : S_MV_DN;
          end
        end
        S_FAULT: begin
          if (act_p) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Watchdog counter and travel direction: cleared/recorded on every entry
  // into a moving state (auto-reverse included), saturating otherwise.
  always_comb begin
    entering_move = ((state_d == S_MV_UP) || (state_d == S_MV_DN)) && (state_d != state_q);
    cnt_d         = cnt_q;
    last_dir_d    = last_dir_q;
    if (entering_move) begin
      cnt_d      = '0;
      last_dir_d = (state_d == S_MV_UP);
    end else if (moving_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State, counter, edge detector and decoded outputs; act_q resets high so a
  // button held through reset does not count as a press.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_dir_q <= 1'b0;
      act_q      <= 1'b1;
      up_m_q     <= 1'b0;
      dn_m_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_dir_q <= last_dir_d;
      act_q      <= Activate;
      up_m_q     <= (state_d == S_MV_UP);
      dn_m_q     <= (state_d == S_MV_DN);
      fault_q    <= (state_d == S_FAULT);
    end
  end

  assign UP_M  = up_m_q;
  assign DN_M  = dn_m_q;
  assign Fault = fault_q;
  assign State = state_q;

endmodule
